// File: rtl/b_priority_decoder_seq_if.sv
// Handshake/output bundle for b_priority_decoder_seq.
//   idx, idx_valid : binary index offered by the upstream block
//   idx_ready      : decoder is idle and can accept
//   q, q_valid     : one-hot output and its qualifier
//   done           : pulse on the last cycle q is driven
//   err            : pulse when an offered index is rejected
//   mask           : per-line permit mask (only with DEC_MASK_EN)
// Optional feature macro: DEC_MASK_EN.
interface b_priority_decoder_seq_if #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned OUT_W = 8
) ();
  logic [IDX_W-1:0] idx;
  logic             idx_valid;
  logic             idx_ready;
  logic [OUT_W-1:0] q;
  logic             q_valid;
  logic             done;
  logic             err;
`ifdef DEC_MASK_EN
  logic [OUT_W-1:0] mask;

  modport master (
    output idx, idx_valid, mask,
    input  idx_ready, q, q_valid, done, err
  );
  modport slave (
    input  idx, idx_valid, mask,
    output idx_ready, q, q_valid, done, err
  );
`else
  modport master (
    output idx, idx_valid,
    input  idx_ready, q, q_valid, done, err
  );
  modport slave (
    input  idx, idx_valid,
    output idx_ready, q, q_valid, done, err
  );
`endif
endinterface

// File: rtl/b_priority_decoder_seq.sv
// Sequential index-to-one-hot decoder. Accepts a binary index over a valid/ready
// handshake, drives the matching one-hot line of q for HOLD cycles, then keeps q
// low for GAP cycles before returning to idle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : b_priority_decoder_seq_if.slave (idx, idx_valid, idx_ready, q, q_valid,
//          done, err, and mask when DEC_MASK_EN is defined)
// Optional feature macro: DEC_MASK_EN (index accepted only if mask[idx] is set).
module b_priority_decoder_seq #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  b_priority_decoder_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] HoldCnt = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GapCnt  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] onehot;
  logic             legal;

  // Decoding through a loop leaves onehot zero for idx >= OUT_W, so legality is
  // simply "some line selected" and no out-of-range bit select is ever formed.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      if (bus.idx == IDX_W'(i)) onehot[i] = 1'b1;
    end
`ifdef DEC_MASK_EN
    legal = |(onehot & bus.mask);
`else
    legal = |onehot;
`endif
  end

  assign bus.idx_ready = (state == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.err  <= 1'b0;
      bus.done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.idx_valid) begin
            if (legal) begin
              state       <= StDrive;
              cnt         <= HoldCnt;
              bus.q       <= onehot;
              bus.q_valid <= 1'b1;
              // done is registered, so it is raised one edge ahead of the last
              // drive cycle; with HOLD=1 the first drive cycle is also the last.
              bus.done    <= (HOLD == 1);
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        StDrive: begin
          if (cnt != '0) begin
            cnt      <= cnt - 1'b1;
            bus.done <= (cnt == CNT_W'(1));
          end else begin
            bus.q       <= '0;
            bus.q_valid <= 1'b0;
            if (GAP > 0) begin
              state <= StGap;
              cnt   <= GapCnt;
            end else begin
              state <= StIdle;
            end
          end
        end
        StGap: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
